// File: rtl/spi_bus_pkg.sv
// Shared constants and FSM encoding for the peripheral SPI bus scheduler.
package spi_bus_pkg;
  localparam int NCH    = 3;
  localparam int LENW   = 6;
  localparam int MAXLEN = 32;

  localparam logic [1:0] CH_BIAS = 2'd0;
  localparam logic [1:0] CH_7794 = 2'd1;
  localparam logic [1:0] CH_3548 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GAP      = 3'd5
  } state_e;
endpackage

// File: rtl/spi_shift_engine.sv
// Phase timer, bit counter and SDI/SDO shift registers for one SPI transaction.
module spi_shift_engine
  import spi_bus_pkg::*;
#(
  parameter int SCK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] wdata,
  input  state_e            st,
  input  logic              sdo,
  output logic              tick,
  output logic              bits_zero,
  output logic              sdi_bit,
  output logic [MAXLEN-1:0] rx_data
);
  localparam int CW = 16;

  logic [CW-1:0]     cnt_q, cnt_d, limit;
  logic [LENW-1:0]   bits_q, bits_d;
  logic [MAXLEN-1:0] tx_q, tx_d, rx_q, rx_d;
  logic              rise;

  // tick marks the last cycle of the current phase; the gap uses its own length.
  assign limit = (st == ST_GAP) ? CW'(CS_GAP - 1) : CW'(SCK_DIV - 1);
  assign tick  = (st != ST_IDLE) && (cnt_q == limit);
  assign rise  = (st == ST_SHIFT_HI) && (cnt_q == '0);

  always_comb begin
    cnt_d  = (st == ST_IDLE || tick) ? '0 : cnt_q + CW'(1);
    bits_d = bits_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (start) begin
      bits_d = len;
      tx_d   = wdata << (LENW'(MAXLEN) - len);
      rx_d   = '0;
    end
    if (rise) begin
      rx_d   = {rx_q[MAXLEN-2:0], sdo};
      bits_d = bits_q - LENW'(1);
    end
    // The last bit is never shifted out so SDI stays put through HOLD.
    if (st == ST_SHIFT_HI && tick && bits_q != '0) tx_d = tx_q << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bits_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bits_q <= bits_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign bits_zero = (bits_q == '0);
  assign sdi_bit   = tx_q[MAXLEN-1];
  assign rx_data   = rx_q;
endmodule

// File: rtl/spi_bus_sched.sv
// Arbitrates three requesters onto the shared SPI bus. Handshake: req is a level held
// until done; grant is one-hot for the transaction; done pulses one cycle with rdata valid.
module spi_bus_sched
  import spi_bus_pkg::*;
#(
  parameter int SCK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*LENW-1:0]    req_len,
  input  logic [NCH*MAXLEN-1:0]  req_wdata,
  output logic [NCH-1:0]         grant,
  output logic [NCH-1:0]         done,
  output logic [MAXLEN-1:0]      rdata,
  output logic                   busy,
  output logic                   SCK,
  output logic                   SDI,
  output logic                   CS_7794,
  output logic                   CS_3548,
  output logic                   CS_BIAS,
  input  logic                   SDO_7794,
  input  logic                   SDO_3548,
  input  logic                   SDO_BIAS,
  output state_e                 dbg_state
);
  state_e            state_q, state_d;
  logic [1:0]        ch_q, ch_d, win;
  logic              zero_q, zero_d, rr_q, rr_d;
  logic [NCH-1:0]    done_q, done_d;
  logic [MAXLEN-1:0] rdata_q, rdata_d, wdata_sel, rx_data;
  logic [LENW-1:0]   len_sel, len_clamp;
  logic              start, tick, bits_zero, sdi_bit, sdo_sel, active, cs_en;

  // rr_q=1 prefers 3548; it flips only when 7794 and 3548 actually contend.
  always_comb begin
    if (req[0])               win = CH_BIAS;
    else if (req[1] && req[2]) win = rr_q ? CH_3548 : CH_7794;
    else if (req[1])          win = CH_7794;
    else                      win = CH_3548;
    case (win)
      CH_7794: begin len_sel = req_len[1*LENW +: LENW]; wdata_sel = req_wdata[1*MAXLEN +: MAXLEN]; end
      CH_3548: begin len_sel = req_len[2*LENW +: LENW]; wdata_sel = req_wdata[2*MAXLEN +: MAXLEN]; end
      default: begin len_sel = req_len[0 +: LENW];      wdata_sel = req_wdata[0 +: MAXLEN]; end
    endcase
    len_clamp = (len_sel > LENW'(MAXLEN)) ? LENW'(MAXLEN) : len_sel;
    // Holding off while done is showing keeps a zero-length requester from being re-granted.
    start = (state_q == ST_IDLE) && (|req) && (done_q == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_SETUP;
      ST_SETUP:    if (zero_q) state_d = ST_IDLE;
                   else if (tick) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_d = bits_zero ? ST_HOLD : ST_SHIFT_LO;
      ST_HOLD:     if (tick) state_d = ST_GAP;
      ST_GAP:      if (tick) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ch_d    = ch_q;
    zero_d  = zero_q;
    rr_d    = rr_q;
    done_d  = '0;
    rdata_d = rdata_q;
    if (start) begin
      ch_d   = win;
      zero_d = (len_clamp == '0);
      if (!req[0] && req[1] && req[2]) rr_d = !rr_q;
    end
    if (state_q == ST_SETUP && zero_q) begin
      done_d  = NCH'(1) << ch_q;
      rdata_d = '0;
    end
    if (state_q == ST_HOLD && tick) begin
      done_d  = NCH'(1) << ch_q;
      rdata_d = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= CH_BIAS;
      zero_q  <= 1'b0;
      rr_q    <= 1'b0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      zero_q  <= zero_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    active  = (state_q == ST_SETUP) || (state_q == ST_SHIFT_LO) ||
              (state_q == ST_SHIFT_HI) || (state_q == ST_HOLD);
    cs_en   = active && !zero_q;
    grant   = active ? (NCH'(1) << ch_q) : '0;
    CS_BIAS = !(cs_en && ch_q == CH_BIAS);
    CS_7794 = !(cs_en && ch_q == CH_7794);
    CS_3548 = !(cs_en && ch_q == CH_3548);
    SCK     = (state_q != ST_SHIFT_LO);
    SDI     = cs_en && sdi_bit;
    busy    = (state_q != ST_IDLE);
    case (ch_q)
      CH_7794: sdo_sel = SDO_7794;
      CH_3548: sdo_sel = SDO_3548;
      default: sdo_sel = SDO_BIAS;
    endcase
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

  spi_shift_engine #(.SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP)) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len_clamp),
    .wdata     (wdata_sel),
    .st        (state_q),
    .sdo       (sdo_sel),
    .tick      (tick),
    .bits_zero (bits_zero),
    .sdi_bit   (sdi_bit),
    .rx_data   (rx_data)
  );
endmodule

// File: tb/tb_spi_bus_sched.sv
// Randomized bench for spi_bus_sched with per-transaction timing and data model.
module tb_spi_bus_sched;
  import spi_bus_pkg::*;
  localparam int SCK_DIV = 4;
  localparam int CS_GAP  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [17:0] req_len = '0;
  logic [95:0] req_wdata = '0;
  logic [2:0]  grant, done;
  logic [31:0] rdata;
  logic        busy, SCK, SDI, CS_7794, CS_3548, CS_BIAS;
  logic        sdo_7794 = 1'b0, sdo_3548 = 1'b0, sdo_bias = 1'b0;
  logic        other_x = 1'b0;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int model_pref = 1;
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  spi_bus_sched #(.SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata), .busy(busy), .SCK(SCK), .SDI(SDI),
    .CS_7794(CS_7794), .CS_3548(CS_3548), .CS_BIAS(CS_BIAS),
    .SDO_7794(sdo_7794), .SDO_3548(sdo_3548), .SDO_BIAS(sdo_bias), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic set_sdo(input int ch, input logic b);
    sdo_bias = (ch == 0) ? b : (other_x ? 1'bx : 1'($urandom_range(0, 1)));
    sdo_7794 = (ch == 1) ? b : (other_x ? 1'bx : 1'($urandom_range(0, 1)));
    sdo_3548 = (ch == 2) ? b : (other_x ? 1'bx : 1'($urandom_range(0, 1)));
  endtask

  // Round-robin rule: bias first; between 7794/3548 the preferred one wins and preference moves.
  function automatic int model_pick(input logic [2:0] r);
    int w;
    if (r[0]) return 0;
    if (r[1] && r[2]) begin
      w = model_pref;
      model_pref = 3 - w;
      return w;
    end
    return r[1] ? 1 : 2;
  endfunction

  task automatic do_txn(input int ch, input int len, input logic [31:0] wd,
                        input logic [31:0] sw, input string nm);
    int eff, t, done_at, idle_at, exp_done, exp_idle, cs_low, other_low, rises, gcnt;
    logic prev_sck, started, cs_me, cs_oth;
    logic [31:0] sdi_got, exp_rd, exp_sdi, rd_done, mask;
    eff      = (len > 32) ? 32 : len;
    mask     = (eff == 32) ? 32'hFFFF_FFFF : ((32'd1 << eff) - 32'd1);
    exp_rd   = sw & mask;
    exp_sdi  = wd & mask;
    exp_done = (eff == 0) ? 1 : SCK_DIV * (2 * eff + 2);
    exp_idle = (eff == 0) ? 1 : exp_done + CS_GAP;
    req_len[6*ch +: 6]    = 6'(len);
    req_wdata[32*ch +: 32] = wd;
    req[ch] = 1'b1;
    set_sdo(ch, 1'b0);
    started = 0; t = 0; done_at = -1; idle_at = -1; cs_low = 0; other_low = 0;
    rises = 0; gcnt = 0; prev_sck = 1'b1; sdi_got = '0; rd_done = '0;
    for (int c = 0; c < 4000 && idle_at < 0; c++) begin
      @(negedge clk);
      if (!started && grant[ch]) started = 1'b1;
      if (started) begin
        cs_me  = (ch == 0) ? CS_BIAS : (ch == 1) ? CS_7794 : CS_3548;
        cs_oth = (ch == 0) ? (CS_7794 & CS_3548) : (ch == 1) ? (CS_BIAS & CS_3548) : (CS_BIAS & CS_7794);
        if (grant[ch]) gcnt++;
        if (!cs_me) cs_low++;
        if (cs_oth !== 1'b1) other_low++;
        if (SCK && !prev_sck) begin
          rises++;
          sdi_got = {sdi_got[30:0], SDI};
          if (rises <= eff) set_sdo(ch, sw[eff - rises]);
        end
        if (done[ch] && done_at < 0) begin
          done_at = t;
          rd_done = rdata;
          req[ch] = 1'b0;
        end
        if (done_at >= 0 && !busy) idle_at = t;
        if (t == 1) begin
          req_len   = 18'($urandom);
          req_wdata = {$urandom, $urandom, $urandom};
        end
        t++;
      end
      prev_sck = SCK;
    end
    n_checks++; if (!started) begin n_fail++; $display("FAIL %s grant_seen: got 0 want 1", nm); end
    n_checks++; if (done_at != exp_done) begin n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", nm, done_at, exp_done); end
    n_checks++; if (idle_at != exp_idle) begin n_fail++; $display("FAIL %s idle_cycle: got %0d want %0d", nm, idle_at, exp_idle); end
    n_checks++; if (gcnt != exp_done) begin n_fail++; $display("FAIL %s grant_cycles: got %0d want %0d", nm, gcnt, exp_done); end
    n_checks++; if (cs_low != ((eff == 0) ? 0 : exp_done)) begin n_fail++; $display("FAIL %s cs_low_cycles: got %0d want %0d", nm, cs_low, (eff == 0) ? 0 : exp_done); end
    n_checks++; if (other_low != 0) begin n_fail++; $display("FAIL %s other_cs_low: got %0d want 0", nm, other_low); end
    n_checks++; if (rises != eff) begin n_fail++; $display("FAIL %s sck_pulses: got %0d want %0d", nm, rises, eff); end
    n_checks++; if ((sdi_got & mask) !== exp_sdi) begin n_fail++; $display("FAIL %s sdi_bits: got %h want %h", nm, sdi_got & mask, exp_sdi); end
    n_checks++; if (rd_done !== exp_rd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", nm, rd_done, exp_rd); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({SCK, SDI, CS_BIAS, CS_7794, CS_3548} !== 5'b10111) begin n_fail++; $display("FAIL reset_pins: got %b want 10111", {SCK, SDI, CS_BIAS, CS_7794, CS_3548}); end
    n_checks++; if ({grant, done} !== 6'b0) begin n_fail++; $display("FAIL reset_grant_done: got %b want 000000", {grant, done}); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, grant, SCK} !== 5'b00001) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00001", {busy, grant, SCK}); end
  endtask

  task automatic test_bias_write();
    do_txn(0, 8, 32'h28, $urandom, "bias_write");
  endtask

  task automatic test_3548_read();
    do_txn(2, 16, $urandom, 32'h1234, "3548_read");
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) do_txn($urandom_range(0, 2), $urandom_range(1, 32), $urandom, $urandom, "random");
  endtask

  task automatic test_len_zero();
    do_txn(1, 0, $urandom, $urandom, "len_zero");
  endtask

  task automatic test_contention();
    logic [2:0] r, tmp, prev_g;
    exp_q.delete();
    got_q.delete();
    for (int p = 0; p < 2; p++) begin
      r = (p == 0) ? 3'b111 : 3'b110;
      tmp = r;
      while (tmp != 0) begin
        int w;
        w = model_pick(tmp);
        exp_q.push_back(2'(w));
        tmp[w] = 1'b0;
      end
      req_len   = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
      req_wdata = {$urandom, $urandom, $urandom};
      @(negedge clk);
      req = r;
      prev_g = '0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (grant != 0 && prev_g == 0) got_q.push_back(grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0);
        prev_g = grant;
        if (done != 0) req = req & ~done;
        if (req == 0 && !busy) break;
      end
    end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL contention_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: got %0d want %0d", i, (i < got_q.size()) ? int'(got_q[i]) : -1, exp_q[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    int rises;
    logic prev;
    wd = $urandom;
    req_len[17:12]   = 6'd16;
    req_wdata[95:64] = wd;
    req[2] = 1'b1;
    set_sdo(2, 1'b0);
    rises = 0;
    prev = 1'b1;
    for (int c = 0; c < 500 && rises < 5; c++) begin
      @(negedge clk);
      if (SCK && !prev) rises++;
      prev = SCK;
    end
    n_checks++; if (rises != 5) begin n_fail++; $display("FAIL reset_mid_reach: got %0d want 5", rises); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({CS_BIAS, CS_7794, CS_3548, SCK} !== 4'b1111) begin n_fail++; $display("FAIL reset_mid_pins: got %b want 1111", {CS_BIAS, CS_7794, CS_3548, SCK}); end
    n_checks++; if ({grant, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_mid_grant: got %b want 0000", {grant, busy}); end
    model_pref = 1;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(2, 16, wd, $urandom, "reset_restart");
  endtask

  task automatic test_clamp_isolation();
    other_x = 1'b1;
    do_txn(1, 40, $urandom, $urandom, "clamp");
    n_checks++; if ($isunknown(rdata)) begin n_fail++; $display("FAIL clamp_rdata_known: got %h want no X", rdata); end
    other_x = 1'b0;
    set_sdo(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bias_write();
    test_3548_read();
    test_random();
    test_len_zero();
    test_contention();
    test_reset_mid();
    test_clamp_isolation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_bus_sched.md
Name: spi_bus_sched

Overview:
- Scheduler and serial engine for the shared peripheral SPI bus: one SCK and one SDI, three chip selects (AD7794, TLC3548, bias CPLD strobe).
- Arbitrates between three requesters: bias-control writer, AD7794 sequencer, TLC3548 poller.
- Runs one MSB-first transaction per grant and returns the captured readback word.
- Sits between the sporta-level sequencers and the board pins.

Parameters:
- SCK_DIV, 4, clk cycles per SCK half-period, >=2.
- CS_GAP, 8, clk cycles all CS held high between transactions, >=1.
- MAXLEN, 32, max bits per transaction; fixes the wdata/rdata width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  level request; [0]=bias, [1]=7794, [2]=3548
- req_len  in  18  three 6-bit bit counts, channel n at [6n+5:6n]
- req_wdata  in  96  three 32-bit words, channel n at [32n+31:32n], right-aligned
- grant  out  3  one-hot, high for whole transaction
- done  out  3  one-cycle completion pulse per channel
- rdata  out  32  captured SDO bits, right-aligned
- busy  out  1  high in any state other than IDLE
- SCK  out  1  serial clock, idles high
- SDI  out  1  serial data to devices
- CS_7794, CS_3548, CS_BIAS  out  1 each  active-low selects
- SDO_7794, SDO_3548, SDO_BIAS  in  1 each  device serial outputs

Behaviour:
- Reset (async, any state):
  - SCK=1, SDI=0, all CS=1.
  - grant=0, done=0, rdata=0, busy=0.
  - State IDLE; round-robin pointer set to 7794.
- States: IDLE -> SETUP -> SHIFT_LO <-> SHIFT_HI -> HOLD -> GAP -> IDLE.
- IDLE:
  - Any req high: arbitrate, assert grant, latch len and wdata of the winner, go to SETUP.
  - Latched values are immune to later input changes.
- Arbitration:
  - bias has strict priority.
  - Between 7794 and 3548, round-robin. The pointer flips only after one of those two is serviced.
- len = 0:
  - Grant for 1 cycle; done pulses the next cycle.
  - rdata=0. No CS or SCK activity. No GAP. Back to IDLE.
  - len > MAXLEN is clamped to MAXLEN.
- SETUP (SCK_DIV cycles):
  - Selected CS low, SCK high.
  - SDI = wdata[len-1].
- SHIFT_LO (SCK_DIV cycles):
  - SCK low.
  - On entry for bits after the first, SDI advances to the next lower bit.
- SHIFT_HI (SCK_DIV cycles):
  - SCK high.
  - In the first cycle of SHIFT_HI (the SCK rising edge), sample the selected device's SDO into the shift register LSB.
  - Bit counter decrements. At 0, go to HOLD; otherwise go to SHIFT_LO.
- HOLD (SCK_DIV cycles): CS low, SCK high, SDI unchanged.
- GAP (CS_GAP cycles):
  - All CS high, SDI=0.
  - First GAP cycle: rdata <= shift register (upper MAXLEN-len bits zero), done[n] pulses, grant drops.
- Total transaction length: SCK_DIV*(2*len+2)+CS_GAP cycles from grant to IDLE.
- rdata holds until the next done.
- CS of unselected devices stays high throughout. SDO of unselected devices is ignored, including X/Z values.
- A req held after its done is re-arbitrated as a new request. Requesters drop req on done.
- Simultaneous req changes during a transaction have no effect until IDLE.

Decomposition:
- Shared package spi_bus_pkg:
  - Channel index constants CH_BIAS=0, CH_7794=1, CH_3548=2, NCH=3.
  - Width constants LENW=6, MAXLEN=32.
  - State enum.
- One sub-module spi_shift_engine: SCK divider, bit counter, SDI/SDO shift registers, driven by start/len/wdata, reporting finish.
- Arbiter, CS decode and done/rdata logic stay in the top.

Test Plan:
- Bias write: req[0], len=8, wdata=0x28, SCK_DIV=4, CS_GAP=8.
  - SDI on SCK rising edges = 0,0,1,0,1,0,0,0.
  - CS_BIAS low 72 cycles; done[0] at cycle 72 after grant; idle at 80.
- 3548 read: device model shifts 0x1234, len=16.
  - rdata=0x1234 at done[2].
  - CS_7794 and CS_BIAS stay high throughout.
- Contention: all three req asserted on the same cycle, each dropped on its done.
  - Grant order bias, 7794, 3548.
  - Re-raising 7794 and 3548 together next gives 3548 first.
- len=0 on 7794: grant[1] for 1 cycle, done[1] the next cycle, rdata=0, SCK and all CS never toggle.
- Reset asserted mid-SHIFT after bit 5 of 16.
  - Same cycle: CS=1, SCK=1, grant=0.
  - After release with req still high, the transaction restarts from bit 15.
- Clamp/isolation: len=40 with SDO_BIAS=X while 7794 is selected.
  - Exactly 32 SCK pulses; rdata contains no X.
